// File: rtl/deser_pkg.sv
// Shared types and frame-length helpers for the serial deserializer.
// Frame length grows by one parity bit when DESER_PARITY_EN is defined.
package deser_pkg;

  localparam int DESER_WIDTH = 8;

  typedef logic [$clog2(DESER_WIDTH+2)-1:0] cnt_t;

  function automatic int frame_len(input int width);
`ifdef DESER_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_bits(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/deser_bit_counter.sv
// Frame bit counter: advances on each qualified bit, wraps after the last one,
// and a sync pulse restarts the frame (the coincident bit becomes bit 0).
module deser_bit_counter
  import deser_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = cnt_bits(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic          i_sync,
  output logic [CW-1:0] o_count,
  output logic          o_last_bit
);

  localparam int FL = frame_len(WIDTH);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;
  logic          w_last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // WIDTH >= 2 guarantees a sync-started frame can never be complete on the sync edge.
  always_comb begin
    w_count_next = r_count;
    w_last_bit   = 1'b0;
    if (i_sync) begin
      w_count_next = i_adv ? CW'(1) : '0;
    end else if (i_adv) begin
      if (r_count == CW'(FL - 1)) begin
        w_count_next = '0;
        w_last_bit   = 1'b1;
      end else begin
        w_count_next = r_count + CW'(1);
      end
    end
  end

  assign o_count    = r_count;
  assign o_last_bit = w_last_bit;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel word assembler with a one-word valid/ready output buffer
// and sticky overrun flag. Optional even parity via DESER_PARITY_EN.
module serial_deserializer
  import deser_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int CW        = cnt_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             bit_valid_in,
  input  logic             sync_in,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic             parity_err
);

  logic [CW-1:0]    w_count;
  logic             w_last_bit;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_word;
  logic             w_data_bit;
  logic             w_load;

  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_word;
  logic             r_valid;
  logic             r_overrun;

  deser_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clk       (clk),
    .rst       (rst),
    .i_adv     (bit_valid_in),
    .i_sync    (sync_in),
    .o_count   (w_count),
    .o_last_bit(w_last_bit)
  );

  // Sync discards the partial word, so the incoming bit shifts into a clean register.
  assign w_base     = sync_in ? '0 : r_shift;
  assign w_shifted  = MSB_FIRST ? {w_base[WIDTH-2:0], data_in}
                                : {data_in, w_base[WIDTH-1:1]};
  // Only data positions shift; a trailing parity bit never enters the word.
  assign w_data_bit = sync_in || (w_count < CW'(WIDTH));
  assign w_load     = w_last_bit && (!r_valid || word_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
    end else if (sync_in && !bit_valid_in) begin
      r_shift <= '0;
    end else if (bit_valid_in && w_data_bit) begin
      r_shift <= w_shifted;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_word  <= w_word;
      r_valid <= 1'b1;
    end else if (r_valid && word_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_last_bit && r_valid && !word_ready) begin
      r_overrun <= 1'b1;
    end else if (clr_overrun) begin
      r_overrun <= 1'b0;
    end
  end

`ifdef DESER_PARITY_EN
  logic r_par;
  logic r_perr;

  // With parity the data bits are complete before the last (parity) edge.
  assign w_word = r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par <= 1'b0;
    end else if (sync_in) begin
      r_par <= bit_valid_in & data_in;
    end else if (bit_valid_in) begin
      r_par <= w_last_bit ? 1'b0 : (r_par ^ data_in);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= r_par ^ data_in;
    end
  end

  assign parity_err = r_perr;
`else
  assign w_word     = w_shifted;
  assign parity_err = 1'b0;
`endif

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: LSB-first and MSB-first instances share
// one stimulus stream. Parity cases run when DESER_PARITY_EN is defined.
module tb_serial_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_in;
  logic       bit_valid_in;
  logic       sync_in;
  logic       word_ready;
  logic       clr_overrun;

  logic [7:0] word_lsb, word_msb;
  logic       valid_lsb, valid_msb;
  logic       ovr_lsb, ovr_msb;
  logic       perr_lsb, perr_msb;

  int checks = 0;
  int errors = 0;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .bit_valid_in(bit_valid_in),
    .sync_in     (sync_in),
    .word_out    (word_lsb),
    .word_valid  (valid_lsb),
    .word_ready  (word_ready),
    .overrun     (ovr_lsb),
    .clr_overrun (clr_overrun),
    .parity_err  (perr_lsb)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .bit_valid_in(bit_valid_in),
    .sync_in     (sync_in),
    .word_out    (word_msb),
    .word_valid  (valid_msb),
    .word_ready  (word_ready),
    .overrun     (ovr_msb),
    .clr_overrun (clr_overrun),
    .parity_err  (perr_msb)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Driver tasks: inputs change 1 time unit after the rising edge, checks sample there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    data_in      = b;
    bit_valid_in = 1'b1;
    tick();
    bit_valid_in = 1'b0;
  endtask

  // seq[i] is the i-th bit on the wire; the final bit is returned for the caller to send.
  task automatic send_all_but_last(input logic [7:0] seq, input logic bad_par, output logic last);
`ifdef DESER_PARITY_EN
    for (int i = 0; i < 8; i++) send_bit(seq[i]);
    last = (^seq) ^ bad_par;
`else
    for (int i = 0; i < 7; i++) send_bit(seq[i]);
    last = seq[7] ^ bad_par;
`endif
  endtask

  task automatic send_frame(input logic [7:0] seq);
    logic last;
    send_all_but_last(seq, 1'b0, last);
    send_bit(last);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic last;

    rst          = 1'b1;
    data_in      = 1'b0;
    bit_valid_in = 1'b0;
    sync_in      = 1'b0;
    word_ready   = 1'b1;
    clr_overrun  = 1'b0;
    tick();
    tick();
    check("rst_word",   {24'd0, word_lsb}, 32'h0);
    check("rst_valid",  {31'd0, valid_lsb}, 32'h0);
    check("rst_ovr",    {31'd0, ovr_lsb}, 32'h0);
    check("rst_perr",   {31'd0, perr_lsb}, 32'h0);
    rst = 1'b0;
    tick();

    // 1/2: 1,0,1,1,0,0,0,0 with ready=1
    send_all_but_last(8'h0D, 1'b0, last);
    check("t1_valid_before_last", {31'd0, valid_lsb}, 32'h0);
    send_bit(last);
    check("t1_valid",     {31'd0, valid_lsb}, 32'h1);
    check("t1_word_lsb",  {24'd0, word_lsb}, 32'h0D);
    check("t2_word_msb",  {24'd0, word_msb}, 32'hB0);
    check("t1_perr",      {31'd0, perr_lsb}, 32'h0);
    tick();
    check("t1_valid_clr", {31'd0, valid_lsb}, 32'h0);
    check("t2_valid_clr", {31'd0, valid_msb}, 32'h0);

    // 3: stalled consumer, two words -> overrun, first word kept
    word_ready = 1'b0;
    send_frame(8'h0D);
    check("t3_valid1",    {31'd0, valid_lsb}, 32'h1);
    check("t3_ovr0",      {31'd0, ovr_lsb}, 32'h0);
    send_frame(8'hFF);
    check("t3_word_kept", {24'd0, word_lsb}, 32'h0D);
    check("t3_ovr1",      {31'd0, ovr_lsb}, 32'h1);
    check("t3_valid2",    {31'd0, valid_lsb}, 32'h1);
    tick();
    check("t3_word_hold", {24'd0, word_lsb}, 32'h0D);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("t3_ovr_clr",   {31'd0, ovr_lsb}, 32'h0);

    // Set wins over a coincident clear
    send_all_but_last(8'hAA, 1'b0, last);
    clr_overrun = 1'b1;
    send_bit(last);
    clr_overrun = 1'b0;
    check("t3_set_wins",  {31'd0, ovr_lsb}, 32'h1);
    check("t3_word_kept2", {24'd0, word_lsb}, 32'h0D);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;

    // Drain and load on the same edge: valid stays high with the new word
    send_all_but_last(8'h5A, 1'b0, last);
    word_ready = 1'b1;
    send_bit(last);
    check("t3_reload_valid", {31'd0, valid_lsb}, 32'h1);
    check("t3_reload_word",  {24'd0, word_lsb}, 32'h5A);
    check("t3_reload_ovr",   {31'd0, ovr_lsb}, 32'h0);
    tick();
    check("t3_drained",   {31'd0, valid_lsb}, 32'h0);

    // 4: three stray bits, then sync with a 1, then zeros
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    sync_in = 1'b1;
    send_bit(1'b1);
    sync_in = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    check("t4_no_early",  {31'd0, valid_lsb}, 32'h0);
`ifdef DESER_PARITY_EN
    send_bit(1'b0);
    send_bit(1'b1);
`else
    send_bit(1'b0);
`endif
    check("t4_valid",     {31'd0, valid_lsb}, 32'h1);
    check("t4_word_lsb",  {24'd0, word_lsb}, 32'h01);
    check("t4_word_msb",  {24'd0, word_msb}, 32'h80);
    check("t4_perr",      {31'd0, perr_lsb}, 32'h0);
    tick();

`ifdef DESER_PARITY_EN
    // 5: good then bad parity on 0x0D
    send_all_but_last(8'h0D, 1'b0, last);
    check("t5_par_bit",   {31'd0, last}, 32'h1);
    send_bit(last);
    check("t5_perr_good", {31'd0, perr_lsb}, 32'h0);
    check("t5_word_good", {24'd0, word_lsb}, 32'h0D);
    tick();
    send_all_but_last(8'h0D, 1'b1, last);
    send_bit(last);
    check("t5_perr_bad",  {31'd0, perr_lsb}, 32'h1);
    check("t5_word_bad",  {24'd0, word_lsb}, 32'h0D);
    check("t5_valid_bad", {31'd0, valid_lsb}, 32'h1);
    tick();
`endif

    // 6: async reset with a buffered word and a partial frame
    word_ready = 1'b0;
    send_frame(8'h33);
    check("t6_valid_pre", {31'd0, valid_lsb}, 32'h1);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    rst = 1'b1;
    #1;
    check("t6_rst_word",  {24'd0, word_lsb}, 32'h0);
    check("t6_rst_valid", {31'd0, valid_lsb}, 32'h0);
    check("t6_rst_ovr",   {31'd0, ovr_lsb}, 32'h0);
    check("t6_rst_perr",  {31'd0, perr_lsb}, 32'h0);
    #1;
    rst = 1'b0;
    word_ready = 1'b1;
    tick();
    send_frame(8'h96);
    check("t6_new_valid", {31'd0, valid_lsb}, 32'h1);
    check("t6_new_lsb",   {24'd0, word_lsb}, 32'h96);
    check("t6_new_msb",   {24'd0, word_msb}, 32'h69);
    check("t6_new_ovr",   {31'd0, ovr_lsb}, 32'h0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
